// File: rtl/delta_frame_ctrl_pkg.sv
// rtl/delta_frame_ctrl_pkg.sv - shared types and default sizes for the delta-frame sequencer
// Purpose: FSM state encoding and default geometry shared by the controller, its
//          address counter and its bus interface.
// Ports:   none (package).
package delta_frame_ctrl_pkg;

   // Encoding is visible on the debug state output, so the values are fixed.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_TRACK   = 2'd2
   } state_t;

   localparam int DEF_COLOR_WIDTH  = 10;
   localparam int DEF_FRAME_PIXELS = 307200;   // 640x480
   localparam int DEF_ADDR_WIDTH   = 19;
   localparam int DEF_PERIOD_WIDTH = 8;

endpackage

// File: rtl/delta_frame_ctrl_if.sv
// rtl/delta_frame_ctrl_if.sv - timing/config inputs and base-RAM/datapath outputs of the sequencer
// Purpose: bundles everything the controller exchanges with the video timing source,
//          the base-frame RAM and the delta datapath.
// Ports (controller view, slave modport):
//   i_enable, i_sof, i_de, i_capture_req        timing and capture control
//   i_cfg_period, i_cfg_threshold, i_cfg_is_filter  requested settings
//   o_base_wr_en, o_base_rd_en, o_base_addr     base-frame RAM port
//   o_is_not_blank, o_threshold, o_is_filter    delta datapath controls
//   o_base_valid, o_err_short, o_state          status / debug
interface delta_frame_ctrl_if #(
   parameter int COLOR_WIDTH  = 10,
   parameter int ADDR_WIDTH   = 19,
   parameter int PERIOD_WIDTH = 8
);
   logic                    i_enable;
   logic                    i_sof;
   logic                    i_de;
   logic                    i_capture_req;
   logic [PERIOD_WIDTH-1:0] i_cfg_period;
   logic [COLOR_WIDTH-1:0]  i_cfg_threshold;
   logic                    i_cfg_is_filter;

   logic                    o_base_wr_en;
   logic                    o_base_rd_en;
   logic [ADDR_WIDTH-1:0]   o_base_addr;
   logic                    o_is_not_blank;
   logic [COLOR_WIDTH-1:0]  o_threshold;
   logic                    o_is_filter;
   logic                    o_base_valid;
   logic                    o_err_short;
   logic [1:0]              o_state;

   // master: timing source / system side
   modport master (
      output i_enable, i_sof, i_de, i_capture_req, i_cfg_period, i_cfg_threshold, i_cfg_is_filter,
      input  o_base_wr_en, o_base_rd_en, o_base_addr, o_is_not_blank, o_threshold, o_is_filter,
             o_base_valid, o_err_short, o_state
   );

   // slave: the sequencer
   modport slave (
      input  i_enable, i_sof, i_de, i_capture_req, i_cfg_period, i_cfg_threshold, i_cfg_is_filter,
      output o_base_wr_en, o_base_rd_en, o_base_addr, o_is_not_blank, o_threshold, o_is_filter,
             o_base_valid, o_err_short, o_state
   );
endinterface

// File: rtl/delta_frame_ctrl_pixel_addr_counter.sv
// rtl/delta_frame_ctrl_pixel_addr_counter.sv - sof-cleared saturating pixel address counter
// Purpose: counts active pixels within a frame and supplies the RAM address of the
//          current pixel; stops at FRAME_PIXELS so overlong frames never wrap.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_sof, i_de      start-of-frame pulse, pixel strobe
//   o_access         current de maps to a RAM location (combinational)
//   o_addr           address of the current pixel (combinational)
//   o_full           previous-frame count reached FRAME_PIXELS (valid at sof)
module delta_frame_ctrl_pixel_addr_counter #(
   parameter int FRAME_PIXELS = 307200,
   parameter int ADDR_WIDTH   = 19
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_sof,
   input  logic                  i_de,
   output logic                  o_access,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_full
);
   localparam logic [ADDR_WIDTH-1:0] LP_FULL = ADDR_WIDTH'(FRAME_PIXELS);

   logic [ADDR_WIDTH-1:0] r_count;
   logic                  w_full;

   // A de coincident with sof is pixel 0 of the new frame, regardless of the old count.
   always_comb begin
      w_full   = (r_count == LP_FULL);
      o_full   = w_full;
      o_addr   = i_sof ? '0 : r_count;
      o_access = i_de && (i_sof || !w_full);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_sof) begin
         r_count <= i_de ? ADDR_WIDTH'(1) : '0;
      end else if (o_access) begin
         r_count <= r_count + ADDR_WIDTH'(1);
      end
   end
endmodule

// File: rtl/delta_frame_ctrl.sv
// rtl/delta_frame_ctrl.sv - frame sequencer driving the base-frame RAM and delta datapath
// Purpose: IDLE/CAPTURE/TRACK sequencer. CAPTURE writes live pixels into the base RAM,
//          TRACK reads them back alongside live video; frame-boundary shadowing of
//          threshold/filter settings, manual and periodic recapture.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   bus (slave)      timing/config inputs, RAM/datapath/status outputs (delta_frame_ctrl_if)
module delta_frame_ctrl
   import delta_frame_ctrl_pkg::*;
#(
   parameter int COLOR_WIDTH  = DEF_COLOR_WIDTH,
   parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH
) (
   input  logic              i_clk,
   input  logic              i_reset,
   delta_frame_ctrl_if.slave bus
);
   state_t                  r_state;
   state_t                  w_state_nx;
   logic                    w_refresh;
   logic                    w_enter_capture;
   logic                    w_access;
   logic                    w_full;
   logic [ADDR_WIDTH-1:0]   w_addr;

   logic                    r_pending;
   logic [PERIOD_WIDTH-1:0] r_frame_cnt;
   logic                    r_base_wr_en;
   logic                    r_base_rd_en;
   logic [ADDR_WIDTH-1:0]   r_base_addr;
   logic [COLOR_WIDTH-1:0]  r_threshold;
   logic                    r_is_filter;
   logic                    r_base_valid;
   logic                    r_err_short;

   delta_frame_ctrl_pixel_addr_counter #(
      .FRAME_PIXELS (FRAME_PIXELS),
      .ADDR_WIDTH   (ADDR_WIDTH)
   ) u_pixel_addr_counter (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_sof    (bus.i_sof),
      .i_de     (bus.i_de),
      .o_access (w_access),
      .o_addr   (w_addr),
      .o_full   (w_full)
   );

   always_comb begin
      w_state_nx = r_state;
      // Refresh fires on the sof that closes the cfg_period-th tracked frame.
      w_refresh  = (bus.i_cfg_period != '0) &&
                   (r_frame_cnt == (bus.i_cfg_period - PERIOD_WIDTH'(1)));
      case (r_state)
         ST_IDLE: begin
            if (bus.i_sof && bus.i_enable) w_state_nx = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (bus.i_sof) begin
               if (!bus.i_enable)  w_state_nx = ST_IDLE;
               else if (w_full)    w_state_nx = ST_TRACK;
            end
         end
         ST_TRACK: begin
            if (bus.i_sof) begin
               if (!bus.i_enable)
                  w_state_nx = ST_IDLE;
               else if (r_pending || bus.i_capture_req || w_refresh)
                  w_state_nx = ST_CAPTURE;
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase
      w_enter_capture = (w_state_nx == ST_CAPTURE) && (r_state != ST_CAPTURE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_pending    <= 1'b0;
         r_frame_cnt  <= '0;
         r_base_wr_en <= 1'b0;
         r_base_rd_en <= 1'b0;
         r_base_addr  <= '0;
         r_threshold  <= '0;
         r_is_filter  <= 1'b0;
         r_base_valid <= 1'b0;
         r_err_short  <= 1'b0;
      end else begin
         r_state <= w_state_nx;

         // The buffer is being overwritten from the first written pixel on.
         if (w_enter_capture)
            r_base_valid <= 1'b0;
         else if (r_state == ST_CAPTURE && bus.i_sof && w_full)
            r_base_valid <= 1'b1;

         if (r_state == ST_CAPTURE && bus.i_sof && !w_full)
            r_err_short <= 1'b1;

         // Entering CAPTURE satisfies any outstanding request.
         if (w_state_nx == ST_CAPTURE)
            r_pending <= 1'b0;
         else if (bus.i_capture_req && r_state != ST_CAPTURE)
            r_pending <= 1'b1;

         if (w_state_nx != ST_TRACK)
            r_frame_cnt <= '0;
         else if (r_state == ST_TRACK && bus.i_sof)
            r_frame_cnt <= r_frame_cnt + PERIOD_WIDTH'(1);

         if (bus.i_sof) begin
            r_threshold <= bus.i_cfg_threshold;
            r_is_filter <= bus.i_cfg_is_filter;
         end

         // Mode of the pixel is the mode of its frame, which a coincident sof has just set.
         r_base_wr_en <= w_access && (w_state_nx == ST_CAPTURE);
         r_base_rd_en <= w_access && (w_state_nx == ST_TRACK);
         if (w_access && w_state_nx != ST_IDLE)
            r_base_addr <= w_addr;
      end
   end

   assign bus.o_base_wr_en   = r_base_wr_en;
   assign bus.o_base_rd_en   = r_base_rd_en;
   assign bus.o_base_addr    = r_base_addr;
   assign bus.o_is_not_blank = r_base_rd_en && r_base_valid;
   assign bus.o_threshold    = r_threshold;
   assign bus.o_is_filter    = r_is_filter;
   assign bus.o_base_valid   = r_base_valid;
   assign bus.o_err_short    = r_err_short;
   assign bus.o_state        = r_state;
endmodule

// File: tb/tb_delta_frame_ctrl.sv
// tb/tb_delta_frame_ctrl.sv - self-checking bench for delta_frame_ctrl with a frame-level model
module tb_delta_frame_ctrl;
   localparam int CW = 10;
   localparam int FP = 16;
   localparam int AW = 5;
   localparam int PW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   delta_frame_ctrl_if #(.COLOR_WIDTH(CW), .ADDR_WIDTH(AW), .PERIOD_WIDTH(PW)) bus();

   delta_frame_ctrl #(
      .COLOR_WIDTH(CW), .FRAME_PIXELS(FP), .ADDR_WIDTH(AW), .PERIOD_WIDTH(PW)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int n_wr, n_rd, last_addr;

   // Frame-level model: mode 0 idle, 1 capture, 2 track.
   int     m_mode, m_pix, m_tracked;
   bit     m_req;
   bit     e_valid, e_err, e_filt, e_wr, e_rd;
   int     e_thr, e_addr;

   task automatic model_step();
      int nm;
      if (rst) begin
         m_mode = 0; m_pix = 0; m_tracked = 0; m_req = 0;
         e_valid = 0; e_err = 0; e_filt = 0; e_wr = 0; e_rd = 0; e_thr = 0; e_addr = 0;
         return;
      end
      if (bus.i_sof) begin
         nm = m_mode;
         if (m_mode == 0) begin
            if (bus.i_enable) nm = 1;
         end else if (m_mode == 1) begin
            if (m_pix == FP) e_valid = 1; else e_err = 1;
            if (!bus.i_enable) nm = 0;
            else if (m_pix == FP) nm = 2;
         end else begin
            m_tracked++;
            if (!bus.i_enable) nm = 0;
            else if (m_req || bus.i_capture_req ||
                     (bus.i_cfg_period != 0 && m_tracked == int'(bus.i_cfg_period))) nm = 1;
         end
         if (bus.i_capture_req && m_mode != 1) m_req = 1;
         if (nm == 1 && m_mode != 1) begin m_req = 0; e_valid = 0; end
         if (nm != 2) m_tracked = 0;
         m_mode = nm;
         m_pix  = 0;
         e_thr  = int'(bus.i_cfg_threshold);
         e_filt = bus.i_cfg_is_filter;
      end else if (bus.i_capture_req && m_mode != 1) begin
         m_req = 1;
      end
      e_wr = 0; e_rd = 0;
      if (bus.i_de && m_pix < FP) begin
         if (m_mode == 1) begin e_wr = 1; e_addr = m_pix; end
         if (m_mode == 2) begin e_rd = 1; e_addr = m_pix; end
         m_pix++;
      end
   endtask

   task automatic compare();
      logic [22:0] act, exp;
      logic [AW-1:0] a_addr, x_addr;
      a_addr = (e_wr || e_rd) ? bus.o_base_addr : '0;
      x_addr = (e_wr || e_rd) ? AW'(e_addr) : '0;
      act = {bus.o_state, bus.o_base_wr_en, bus.o_base_rd_en, bus.o_is_not_blank,
             bus.o_base_valid, bus.o_err_short, bus.o_is_filter, bus.o_threshold, a_addr};
      exp = {2'(m_mode), e_wr, e_rd, e_rd, e_valid, e_err, e_filt, CW'(e_thr), x_addr};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL cycle_outputs t=%0t act=%h exp=%h (state,wr,rd,nb,valid,err,filt,thr,addr)",
                  $time, act, exp);
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   task automatic cyc(input bit s, input bit d, input bit r);
      bus.i_sof = s; bus.i_de = d; bus.i_capture_req = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      if (bus.o_base_wr_en === 1'b1) begin n_wr++; last_addr = int'(bus.o_base_addr); end
      if (bus.o_base_rd_en === 1'b1) begin n_rd++; last_addr = int'(bus.o_base_addr); end
   endtask

   // One frame: sof, n_de pixels (first on the sof cycle if sof_de), two blank cycles.
   // At pixel req_at a capture_req is pulsed; at pixel chg_at the config changes to thr/filt.
   task automatic frame(input int n_de, input bit sof_de, input int req_at,
                        input int chg_at, input int thr, input bit filt);
      n_wr = 0; n_rd = 0; last_addr = -1;
      cyc(1'b1, sof_de, 1'b0);
      for (int i = (sof_de ? 1 : 0); i < n_de; i++) begin
         if (i == chg_at) begin
            bus.i_cfg_threshold = CW'(thr);
            bus.i_cfg_is_filter = filt;
         end
         cyc(1'b0, 1'b1, i == req_at);
      end
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bus.i_enable = 1'b1; bus.i_sof = 1'b0; bus.i_de = 1'b0; bus.i_capture_req = 1'b0;
      bus.i_cfg_period = '0; bus.i_cfg_threshold = CW'(100); bus.i_cfg_is_filter = 1'b0;
      rst = 1'b1;
      cyc(0, 0, 0); cyc(0, 0, 0);
      lit("reset_state", int'(bus.o_state), 0);
      lit("reset_valid", int'(bus.o_base_valid), 0);
      rst = 1'b0;

      // Clean capture, then into TRACK
      frame(FP, 0, -1, -1, 0, 0);
      lit("cap_state", int'(bus.o_state), 1);
      lit("cap_writes", n_wr, FP);
      lit("cap_last_addr", last_addr, FP - 1);
      frame(FP, 0, -1, -1, 0, 0);
      lit("trk_state", int'(bus.o_state), 2);
      lit("trk_valid", int'(bus.o_base_valid), 1);
      lit("trk_reads", n_rd, FP);

      // Mid-frame capture_req and threshold change 100->200
      frame(FP, 0, 5, 3, 200, 1);
      lit("thr_held", int'(bus.o_threshold), 100);
      lit("req_state_hold", int'(bus.o_state), 2);
      frame(FP, 0, -1, -1, 0, 0);
      lit("req_state_cap", int'(bus.o_state), 1);
      lit("req_valid_clr", int'(bus.o_base_valid), 0);
      lit("req_no_reads", n_rd, 0);
      lit("thr_new", int'(bus.o_threshold), 200);
      lit("filt_new", int'(bus.o_is_filter), 1);
      frame(FP, 0, -1, -1, 0, 0);

      // Periodic refresh every 3 tracked frames; first one has de on the sof cycle
      bus.i_cfg_period = PW'(3);
      frame(FP, 1, -1, -1, 0, 0);
      lit("sofde_reads", n_rd, FP);
      lit("sofde_last_addr", last_addr, FP - 1);
      frame(FP, 0, -1, -1, 0, 0);
      lit("per_frame2", int'(bus.o_state), 2);
      frame(FP, 0, -1, -1, 0, 0);
      lit("per_refresh", int'(bus.o_state), 1);
      frame(FP, 0, -1, -1, 0, 0);
      bus.i_cfg_period = '0;
      for (int k = 0; k < 4; k++) frame(FP, 0, -1, -1, 0, 0);
      lit("per_off_state", int'(bus.o_state), 2);

      // Short capture frame, then overlong one that saturates
      frame(FP, 0, 2, -1, 0, 0);
      frame(5, 0, -1, -1, 0, 0);
      lit("short_state", int'(bus.o_state), 1);
      frame(FP + 5, 0, -1, -1, 0, 0);
      lit("short_err", int'(bus.o_err_short), 1);
      lit("short_retry_state", int'(bus.o_state), 1);
      lit("long_writes", n_wr, FP);
      lit("long_last_addr", last_addr, FP - 1);
      frame(FP, 0, -1, -1, 0, 0);
      lit("long_state", int'(bus.o_state), 2);
      lit("long_valid", int'(bus.o_base_valid), 1);

      // Disable drops to IDLE; re-enable starts a capture that is reset midway
      bus.i_enable = 1'b0;
      frame(FP, 0, -1, -1, 0, 0);
      lit("idle_state", int'(bus.o_state), 0);
      lit("idle_reads", n_rd, 0);
      bus.i_enable = 1'b1;
      cyc(1, 0, 0);
      for (int i = 0; i < 6; i++) cyc(0, 1, 0);
      lit("midcap_state", int'(bus.o_state), 1);
      rst = 1'b1;
      cyc(0, 1, 0);
      rst = 1'b0;
      lit("rst_state", int'(bus.o_state), 0);
      lit("rst_valid", int'(bus.o_base_valid), 0);
      lit("rst_wr", int'(bus.o_base_wr_en), 0);
      lit("rst_err", int'(bus.o_err_short), 0);
      cyc(0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
